// File: rtl/pwm_pkg.sv
// Shared types for the brake-lamp / motor PWM drive: duty word and ramp FSM states.
package pwm_pkg;

    localparam int PWM_WIDTH = 10;

    typedef logic [PWM_WIDTH-1:0] duty_t;

    localparam duty_t DUTY_FULL = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RAMP = 2'd1,
        HOLD = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Tick generator: one-clock tick every PRESCALE+1 clocks, held at zero while cleared.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESCALE = 49
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (clear || (count_q == LAST)) begin
            count_d = '0;
        end
    end

    // With PRESCALE=0 the count sits at LAST permanently, so gating on clear keeps IDLE tick-free.
    assign tick = !clear && (count_q == LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/pwm_ramp_generator.sv
// Glitch-free PWM drive with period-boundary duty updates and an optional per-period ramp limit.
module pwm_ramp_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH,
    parameter int PRESCALE  = 49,
    parameter int OFFSET    = 0,
    parameter int RAMP_STEP = 8
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] PWMinput,
    output logic             PWMout,
    output logic             periodStart,
    output logic [WIDTH-1:0] dutyActive,
    output logic             atTarget
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_INIT = WIDTH'(OFFSET);
    localparam logic [WIDTH:0]   STEP_X   = (WIDTH + 1)'(RAMP_STEP);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(RAMP_STEP);

    // Moves cur toward tgt by at most RAMP_STEP; the add/subtract only happens when the
    // gap exceeds the step, so it can never wrap past zero or full scale.
    function automatic logic [WIDTH-1:0] ramp_toward(input logic [WIDTH-1:0] cur,
                                                     input logic [WIDTH-1:0] tgt);
        logic [WIDTH:0] diff;
        ramp_toward = tgt;
        diff        = '0;
        if (RAMP_STEP != 0) begin
            if (tgt > cur) begin
                diff = {1'b0, tgt} - {1'b0, cur};
                if (diff > STEP_X) begin
                    ramp_toward = cur + STEP_W;
                end
            end else begin
                diff = {1'b0, cur} - {1'b0, tgt};
                if (diff > STEP_X) begin
                    ramp_toward = cur - STEP_W;
                end
            end
        end
    endfunction

    pwm_state_t       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             pwm_q, pwm_d;
    logic             period_start_q, period_start_d;
    logic             at_target_q, at_target_d;

    logic             presc_clear;
    logic             tick;
    logic             boundary;
    logic [WIDTH-1:0] next_duty;

    assign presc_clear = (state_q == IDLE) || !enable;

    pwm_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .clear    (presc_clear),
        .tick     (tick)
    );

    assign boundary  = tick && (cnt_q == CNT_MAX);
    assign next_duty = ramp_toward(duty_q, target_q);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        duty_d         = duty_q;
        pwm_d          = 1'b0;
        period_start_d = 1'b0;
        at_target_d    = (duty_q == target_q);
        target_d       = PWMinput;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = CNT_INIT;
            duty_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RAMP;
                    cnt_d   = CNT_INIT;
                    duty_d  = '0;
                end
                RAMP, HOLD: begin
                    pwm_d = (duty_q == CNT_MAX) || (cnt_q < duty_q);
                    if (tick) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // target_q is the pre-edge value here, so a same-cycle input change waits a period.
                    if (boundary) begin
                        duty_d         = next_duty;
                        period_start_d = 1'b1;
                        state_d        = (next_duty == target_q) ? HOLD : RAMP;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_INIT;
                    duty_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= CNT_INIT;
            duty_q         <= '0;
            target_q       <= '0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            at_target_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            duty_q         <= duty_d;
            target_q       <= target_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            at_target_q    <= at_target_d;
        end
    end

    assign PWMout      = pwm_q;
    assign periodStart = period_start_q;
    assign dutyActive  = duty_q;
    assign atTarget    = at_target_q;

endmodule
